// File: rtl/debug_controller.sv
// Host-side debug sequencer for the MIPS pipeline: decodes UART commands, loads
// instruction memory, drives run/step, and streams a state dump back byte by byte.
module debug_controller #(
    parameter int NB          = 32,
    parameter int NB_BYTE     = 8,
    parameter int NB_REGS     = 5,
    parameter int N_MEM_WORDS = 16,
    parameter int MAX_INSTR   = 256
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    input  logic [NB-1:0]      i_mips_pc,
    input  logic [NB-1:0]      i_mips_alu_result,
    input  logic [NB-1:0]      i_mips_register_data,
    input  logic [NB-1:0]      i_mips_data_memory,
    input  logic               i_mips_wb_halt,
    output logic               o_step,
    output logic [NB_REGS-1:0] o_debug_register_number,
    output logic [NB-1:0]      o_debug_address,
    output logic               o_instruction_write_enable,
    output logic [NB-1:0]      o_instruction_address,
    output logic [NB-1:0]      o_instruction_data
);

    localparam int BYTES_PER_WORD = NB / NB_BYTE;
    localparam int NB_BCNT        = $clog2(BYTES_PER_WORD);
    localparam int NB_WIDX        = $clog2(MAX_INSTR + 1);
    localparam int REG_BASE       = 2;
    localparam int MEM_BASE       = REG_BASE + (1 << NB_REGS);
    localparam int N_SLOTS        = MEM_BASE + N_MEM_WORDS;
    localparam int NB_SLOT        = $clog2(N_SLOTS);

    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);

    typedef enum logic [3:0] {
        IDLE, LOAD_COUNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP,
        DUMP_SEL, DUMP_LATCH, DUMP_SEND, DUMP_WAIT
    } state_t;

    state_t               state, state_next;
    logic [NB_BCNT-1:0]   byte_cnt;
    logic [NB_BCNT-1:0]   tx_byte;
    logic [NB_WIDX-1:0]   word_idx, word_total, word_idx_inc, count_sat;
    logic [NB_SLOT-1:0]   slot;
    logic [NB-1:0]        instr_word;
    logic [NB-1:0]        shift;
    logic [NB-1:0]        dump_src;
    logic                 last_tx_byte, last_slot;

    assign word_idx_inc = word_idx + NB_WIDX'(1);
    assign last_tx_byte = (tx_byte == NB_BCNT'(BYTES_PER_WORD - 1));
    assign last_slot    = (slot == NB_SLOT'(N_SLOTS - 1));

    always_comb begin
        if (int'(i_rx_data) > MAX_INSTR) count_sat = NB_WIDX'(MAX_INSTR);
        else                             count_sat = NB_WIDX'(i_rx_data);
    end

    // Dump slots: 0 = PC, 1 = ALU result, then registers, then data-memory words.
    always_comb begin
        o_debug_register_number = '0;
        o_debug_address         = '0;
        dump_src                = i_mips_data_memory;
        if (slot == '0) begin
            dump_src = i_mips_pc;
        end else if (slot == NB_SLOT'(1)) begin
            dump_src = i_mips_alu_result;
        end else if (slot < NB_SLOT'(MEM_BASE)) begin
            o_debug_register_number = NB_REGS'(slot - NB_SLOT'(REG_BASE));
            dump_src                = i_mips_register_data;
        end else begin
            o_debug_address = NB'(slot - NB_SLOT'(MEM_BASE)) << 2;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next                 = state;
        o_step                     = 1'b0;
        o_tx_start                 = 1'b0;
        o_instruction_write_enable = 1'b0;
        case (state)
            IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: state_next = LOAD_COUNT;
                        CMD_CONT: state_next = i_mips_wb_halt ? DUMP_SEL : RUN;
                        CMD_STEP: state_next = i_mips_wb_halt ? DUMP_SEL : STEP;
                        default:  state_next = IDLE;
                    endcase
                end
            end
            LOAD_COUNT: begin
                if (i_rx_done) state_next = (i_rx_data == '0) ? IDLE : LOAD_BYTE;
            end
            LOAD_BYTE: begin
                if (i_rx_done && byte_cnt == NB_BCNT'(BYTES_PER_WORD - 1)) state_next = LOAD_WRITE;
            end
            LOAD_WRITE: begin
                o_instruction_write_enable = 1'b1;
                state_next = (word_idx_inc == word_total) ? IDLE : LOAD_BYTE;
            end
            RUN: begin
                if (i_mips_wb_halt) state_next = DUMP_SEL;
                else                o_step     = 1'b1;
            end
            STEP: begin
                o_step     = 1'b1;
                state_next = DUMP_SEL;
            end
            DUMP_SEL:   state_next = DUMP_LATCH;
            DUMP_LATCH: state_next = DUMP_SEND;
            DUMP_SEND: begin
                o_tx_start = 1'b1;
                state_next = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (i_tx_done) begin
                    if (!last_tx_byte)  state_next = DUMP_SEND;
                    else if (last_slot) state_next = IDLE;
                    else                state_next = DUMP_SEL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            byte_cnt   <= '0;
            tx_byte    <= '0;
            word_idx   <= '0;
            word_total <= '0;
            slot       <= '0;
            instr_word <= '0;
            shift      <= '0;
        end else begin
            case (state)
                LOAD_COUNT: begin
                    if (i_rx_done) begin
                        word_total <= count_sat;
                        word_idx   <= '0;
                        byte_cnt   <= '0;
                    end
                end
                LOAD_BYTE: begin
                    // Little-endian: each new byte enters at the top and slides down.
                    if (i_rx_done) begin
                        instr_word <= {i_rx_data, instr_word[NB-1:NB_BYTE]};
                        byte_cnt   <= byte_cnt + NB_BCNT'(1);
                    end
                end
                LOAD_WRITE: begin
                    word_idx <= (word_idx_inc == word_total) ? '0 : word_idx_inc;
                end
                DUMP_LATCH: begin
                    shift   <= dump_src;
                    tx_byte <= '0;
                end
                DUMP_WAIT: begin
                    if (i_tx_done) begin
                        shift   <= shift >> NB_BYTE;
                        tx_byte <= tx_byte + NB_BCNT'(1);
                        if (last_tx_byte) slot <= last_slot ? '0 : slot + NB_SLOT'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tx_data             = shift[NB_BYTE-1:0];
    assign o_instruction_address = (state == LOAD_WRITE) ? (NB'(word_idx) << 2) : '0;
    assign o_instruction_data    = (state == LOAD_WRITE) ? instr_word : '0;

endmodule
